exu_mdu: RTL and testbench
==========================

// Module: exu_mdu
// PURPOSE
//  RV32M multiply/divide unit inside the execute stage. It takes M-extension ops from the IDU2EXU pipeline register outputs.
//  Multiply ops complete in a fixed 2 cycles; divide/remainder ops use an iterative radix-2 restoring divider.
//  mdu_stall holds IDU2EXU and the upstream stages while an op is in flight.
//  A branch/jump redirect (flush) kills the op in flight.
// PARAMETERS
//  XLEN     32  operand/result width; must be even and >= 8
//  CNT_W    6   iteration counter width, >= clog2(XLEN)+1
// PORTS
//  clk          in   1     clock; single clock domain
//  rst_n        in   1     asynchronous active-low reset
//  mdu_start    in   1     valid M-op in EXU (idu2exu_en_r & M-ext decode); level, held while stalled
//  mdu_funct3   in   3     inst[14:12]: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
//  mdu_src1     in   XLEN  rs1 value (post-forwarding)
//  mdu_src2     in   XLEN  rs2 value (post-forwarding)
//  mdu_flush    in   1     exu2idu_branch_en | exu2idu_jump_en
//  mdu_stall    out  1     hold pipeline; combinational
//  mdu_busy     out  1     state is MUL or DIV
//  mdu_done     out  1     one-cycle pulse; mdu_result valid
//  mdu_result   out  XLEN  registered result; holds until next accepted start
// BEHAVIOUR
//  Reset values:
//   - state=IDLE; mdu_done=0; mdu_busy=0; mdu_result=0.
//   - Internal operand, quotient and remainder registers = 0; cnt = 0.
//  FSM states: IDLE, MUL, DIV, DONE.
//  IDLE:
//   - start & ~flush accepts the op; latches funct3 and operands.
//   - funct3<4 -> MUL.
//   - funct3>=4 with divisor==0 -> DONE.
//   - funct3==4/6 with src1==MIN (0x80..0) and src2==all-ones -> DONE (signed overflow).
//   - Any other divide -> DIV with cnt=0; operands are converted to magnitudes for signed ops.
//  MUL: forms a 2*XLEN product of sign/zero-extended (XLEN+1)-bit operands -> DONE.
//   - MUL returns the low half; MULH/MULHSU/MULHU return the high half.
//  DIV:
//   - One restoring step per cycle; cnt increments each cycle.
//   - On the step with cnt==XLEN-1: apply sign correction, then -> DONE.
//   - Signed quotient is negative iff operand signs differ.
//   - Signed remainder takes the dividend's sign.
//  DONE: mdu_done=1 for this cycle only; start is ignored here (same instruction leaves EXU); -> IDLE.
//  Divide special results:
//   - div by 0: DIV/DIVU = all-ones; REM/REMU = src1.
//   - Overflow: DIV = MIN; REM = 0.
//  Latency (edges from the accepting edge to done high):
//   - MUL family: 2.
//   - Divide special case: 1.
//   - Normal divide: XLEN+1.
//  mdu_stall = (IDLE & start & ~flush) | MUL | DIV; it is 0 in DONE so the pipeline advances at the end of DONE.
//  Throughput: a new op can be accepted in the first IDLE cycle after DONE; back-to-back ops have one bubble-free handoff.
//  Flush:
//   - In any state, the next state is IDLE.
//   - done is not asserted for the killed op; mdu_result is not updated.
//   - flush & start in the same cycle: flush wins and the op is not accepted.
//  Reset mid-operation: everything returns to reset values immediately; no done pulse.
//  Arithmetic is modulo 2^XLEN; no exceptions are raised.
//  mdu_result is written only on the edge into DONE.
// TESTING
//  1. MULHU 0xFFFFFFFF,0xFFFFFFFF -> result 0xFFFFFFFE, done 2 edges after accept; MUL -> 0x00000001.
//  2. MULH 0xFFFFFFFF,0xFFFFFFFF -> 0x00000000; MULHSU 0xFFFFFFFF,0x00000002 -> 0xFFFFFFFF.
//  3. DIV -7,2 -> 0xFFFFFFFD; REM -7,2 -> 0xFFFFFFFF.
//     Done at 33 edges; stall high for exactly 33 cycles.
//  4. DIVU 5,0 -> 0xFFFFFFFF; REMU 5,0 -> 5.
//     DIV 0x80000000,0xFFFFFFFF -> 0x80000000; REM of the same operands -> 0.
//     All of these: done 1 edge after accept.
//  5. Flush in DIV at cnt=10 -> busy=0 next cycle, no done, result unchanged.
//     A new MUL 3,4 accepted next cycle -> 12.
//  6. Assert rst_n=0 mid-DIV -> all outputs 0 asynchronously.
//     Release, then issue DIVU 100,7 -> 14; REMU 100,7 -> 2.

Source files
------------

// File: rtl/exu_mdu_if.sv
// Handshake and data bundle between the execute-stage pipeline and the RV32M multiply/divide unit.
// The pipeline side drives the op and its operands. The MDU side returns stall, busy, done and the result.
interface exu_mdu_if #(
  parameter int XLEN = 32
);
  logic            mdu_start;
  logic [2:0]      mdu_funct3;
  logic [XLEN-1:0] mdu_src1;
  logic [XLEN-1:0] mdu_src2;
  logic            mdu_flush;
  logic            mdu_stall;
  logic            mdu_busy;
  logic            mdu_done;
  logic [XLEN-1:0] mdu_result;

  modport master (
    output mdu_start, mdu_funct3, mdu_src1, mdu_src2, mdu_flush,
    input  mdu_stall, mdu_busy, mdu_done, mdu_result
  );

  modport slave (
    input  mdu_start, mdu_funct3, mdu_src1, mdu_src2, mdu_flush,
    output mdu_stall, mdu_busy, mdu_done, mdu_result
  );
endinterface

// File: rtl/exu_mdu.sv
// RV32M multiply/divide unit: 2-cycle multiply, iterative radix-2 restoring divide, flushable.
// state  | meaning
// S_IDLE | waiting for an M-op; accepts on start & ~flush
// S_MUL  | product of latched operands formed, result written on exit
// S_DIV  | one restoring step per cycle, cnt counts steps
// S_DONE | one-cycle done pulse, stall released
module exu_mdu #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  exu_mdu_if.slave   mdu
);
  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

  state_t            state, state_nxt;
  logic [1:0]        op_r;
  logic [XLEN-1:0]   op_a, op_b, quo, rem, result_r;
  logic [CNT_W-1:0]  cnt;
  logic              neg_q, neg_r;

  logic              accept, div_zero, div_ovf, special, sgn_div;
  logic [XLEN-1:0]   src1_mag, src2_mag, special_res;
  logic [XLEN:0]     shifted, diff;
  logic [XLEN-1:0]   q_step, r_step, div_res, mul_res;
  logic              last_step, a_sgn, b_sgn;
  logic [2*XLEN-1:0] a_ext, b_ext, prod;

  assign accept   = (state == S_IDLE) & mdu.mdu_start & ~mdu.mdu_flush;
  assign sgn_div  = ~mdu.mdu_funct3[0];
  assign div_zero = (mdu.mdu_src2 == '0);
  assign div_ovf  = sgn_div & (mdu.mdu_src1 == MIN_VAL) & (mdu.mdu_src2 == '1);
  assign special  = mdu.mdu_funct3[2] & (div_zero | div_ovf);
  assign src1_mag = (sgn_div & mdu.mdu_src1[XLEN-1]) ? -mdu.mdu_src1 : mdu.mdu_src1;
  assign src2_mag = (sgn_div & mdu.mdu_src2[XLEN-1]) ? -mdu.mdu_src2 : mdu.mdu_src2;
  assign special_res = div_zero ? (mdu.mdu_funct3[1] ? mdu.mdu_src1 : '1)
                                : (mdu.mdu_funct3[1] ? '0 : MIN_VAL);

  // Restoring step: the dividend bits shift out of quo while quotient bits shift in.
  assign shifted   = {rem, quo[XLEN-1]};
  assign diff      = shifted - {1'b0, op_b};
  assign q_step    = {quo[XLEN-2:0], ~diff[XLEN]};
  assign r_step    = diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
  assign last_step = (cnt == CNT_W'(XLEN-1));
  assign div_res   = op_r[1] ? (neg_r ? -r_step : r_step)
                             : (neg_q ? -q_step : q_step);

  // The low 2*XLEN bits of a sign-extended product are exact for every signedness mix.
  assign a_sgn   = (op_r == 2'd1) | (op_r == 2'd2);
  assign b_sgn   = (op_r == 2'd1);
  assign a_ext   = {{XLEN{a_sgn & op_a[XLEN-1]}}, op_a};
  assign b_ext   = {{XLEN{b_sgn & op_b[XLEN-1]}}, op_b};
  assign prod    = a_ext * b_ext;
  assign mul_res = (op_r == 2'd0) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (accept) begin
        if (!mdu.mdu_funct3[2]) state_nxt = S_MUL;
        else if (special)       state_nxt = S_DONE;
        else                    state_nxt = S_DIV;
      end
      S_MUL:  state_nxt = S_DONE;
      S_DIV:  if (last_step) state_nxt = S_DONE;
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if (mdu.mdu_flush) state_nxt = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_r     <= '0;
      op_a     <= '0;
      op_b     <= '0;
      quo      <= '0;
      rem      <= '0;
      cnt      <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      result_r <= '0;
    end else if (accept) begin
      op_r  <= mdu.mdu_funct3[1:0];
      op_a  <= mdu.mdu_src1;
      op_b  <= mdu.mdu_funct3[2] ? src2_mag : mdu.mdu_src2;
      quo   <= src1_mag;
      rem   <= '0;
      cnt   <= '0;
      neg_q <= sgn_div & (mdu.mdu_src1[XLEN-1] ^ mdu.mdu_src2[XLEN-1]);
      neg_r <= sgn_div & mdu.mdu_src1[XLEN-1];
      if (special) result_r <= special_res;
    end else if (state == S_MUL && !mdu.mdu_flush) begin
      result_r <= mul_res;
    end else if (state == S_DIV && !mdu.mdu_flush) begin
      quo <= q_step;
      rem <= r_step;
      cnt <= cnt + CNT_W'(1);
      if (last_step) result_r <= div_res;
    end
  end

  assign mdu.mdu_stall  = accept | (state == S_MUL) | (state == S_DIV);
  assign mdu.mdu_busy   = (state == S_MUL) | (state == S_DIV);
  assign mdu.mdu_done   = (state == S_DONE);
  assign mdu.mdu_result = result_r;
endmodule

// File: tb/tb_exu_mdu.sv
// Directed bench for exu_mdu: results, latency, stall length, flush and async reset behaviour.
module tb_exu_mdu;
  localparam int XLEN = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  typedef struct {
    logic [31:0] res;
    int          lat;
    string       tag;
  } exp_t;
  exp_t sb[$];

  exu_mdu_if #(.XLEN(XLEN)) bus ();
  exu_mdu #(.XLEN(XLEN), .CNT_W(6)) u_dut (.clk(clk), .rst_n(rst_n), .mdu(bus));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int lat);
    exp_t e;
    int   edges;
    int   stalls;
    logic seen;
    @(negedge clk);
    bus.mdu_funct3 = f3;
    bus.mdu_src1   = a;
    bus.mdu_src2   = b;
    bus.mdu_start  = 1'b1;
    e.res = exp; e.lat = lat; e.tag = tag;
    sb.push_back(e);
    #1 stalls = bus.mdu_stall ? 1 : 0;
    edges = 0;
    seen  = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(posedge clk); #1;
      edges++;
      if (bus.mdu_stall) stalls++;
      if (bus.mdu_done) seen = 1'b1;
    end
    bus.mdu_start = 1'b0;
    e = sb.pop_front();
    chk({e.tag, "_done"}, 32'(seen), 32'd1);
    chk({e.tag, "_result"}, bus.mdu_result, e.res);
    chk({e.tag, "_latency"}, 32'(edges), 32'(e.lat));
    chk({e.tag, "_stall"}, 32'(stalls), 32'(e.lat));
    @(posedge clk); #1;
    chk({e.tag, "_done_pulse"}, 32'(bus.mdu_done), 32'd0);
  endtask

  initial begin
    bus.mdu_start  = 1'b0;
    bus.mdu_flush  = 1'b0;
    bus.mdu_funct3 = 3'd0;
    bus.mdu_src1   = '0;
    bus.mdu_src2   = '0;
    #1;
    chk("rst_busy", 32'(bus.mdu_busy), 32'd0);
    chk("rst_done", 32'(bus.mdu_done), 32'd0);
    chk("rst_stall", 32'(bus.mdu_stall), 32'd0);
    chk("rst_result", bus.mdu_result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("mulhu",  3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 2);
    run_op("mul",    3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 2);
    run_op("mulh",   3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 2);
    run_op("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 2);
    run_op("mulh_min", 3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 2);
    run_op("div_m7_2", 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
    run_op("rem_m7_2", 3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
    run_op("div_7_m2", 3'd4, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 33);
    run_op("rem_7_m2", 3'd6, 32'd7, 32'hFFFF_FFFE, 32'h0000_0001, 33);
    run_op("divu_5_0", 3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
    run_op("remu_5_0", 3'd7, 32'd5, 32'd0, 32'h0000_0005, 1);
    run_op("div_ovf",  3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    run_op("rem_ovf",  3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1);
    run_op("div_5_0",  3'd4, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
    run_op("rem_m5_0", 3'd6, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 1);
    run_op("divu_max", 3'd5, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 33);

    // Flush during DIV at cnt=10: no done, result keeps the divu_max value.
    @(negedge clk);
    bus.mdu_funct3 = 3'd4; bus.mdu_src1 = 32'd1000; bus.mdu_src2 = 32'd3;
    bus.mdu_start  = 1'b1;
    @(posedge clk);
    repeat (10) @(posedge clk);
    @(negedge clk);
    bus.mdu_flush = 1'b1;
    bus.mdu_start = 1'b0;
    @(posedge clk); #1;
    chk("flush_busy", 32'(bus.mdu_busy), 32'd0);
    chk("flush_done", 32'(bus.mdu_done), 32'd0);
    @(negedge clk);
    bus.mdu_flush = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("flush_no_done", 32'(bus.mdu_done), 32'd0);
    end
    chk("flush_result_held", bus.mdu_result, 32'hFFFF_FFFF);
    run_op("mul_3_4", 3'd0, 32'd3, 32'd4, 32'd12, 2);

    // Flush and start together: the op must not be accepted.
    @(negedge clk);
    bus.mdu_funct3 = 3'd0; bus.mdu_src1 = 32'd5; bus.mdu_src2 = 32'd5;
    bus.mdu_start  = 1'b1;
    bus.mdu_flush  = 1'b1;
    #1 chk("flush_start_stall", 32'(bus.mdu_stall), 32'd0);
    @(posedge clk); #1;
    chk("flush_start_busy", 32'(bus.mdu_busy), 32'd0);
    @(negedge clk);
    bus.mdu_start = 1'b0;
    bus.mdu_flush = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk("flush_start_result", bus.mdu_result, 32'd12);

    // Asynchronous reset in the middle of a divide.
    @(negedge clk);
    bus.mdu_funct3 = 3'd5; bus.mdu_src1 = 32'd100; bus.mdu_src2 = 32'd7;
    bus.mdu_start  = 1'b1;
    repeat (6) @(posedge clk);
    #2;
    chk("pre_rst_busy", 32'(bus.mdu_busy), 32'd1);
    rst_n = 1'b0;
    bus.mdu_start = 1'b0;
    #1;
    chk("arst_busy", 32'(bus.mdu_busy), 32'd0);
    chk("arst_done", 32'(bus.mdu_done), 32'd0);
    chk("arst_stall", 32'(bus.mdu_stall), 32'd0);
    chk("arst_result", bus.mdu_result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("divu_100_7", 3'd5, 32'd100, 32'd7, 32'd14, 33);
    run_op("remu_100_7", 3'd7, 32'd100, 32'd7, 32'd2, 33);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
